// File: rtl/multi_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_unit
//
// Control FSM for a multi-cycle RV32 subset datapath. Sequences each
// instruction through IF / ID / EX / MEM / WB. ECALL with x17==10 parks the
// machine in HALTED until reset.
//
// Ports
//   clk            single clock, all state changes on the rising edge
//   reset          asynchronous active-high reset, forces state to IF
//   opcode         instruction[6:0] from the IR (meaningful from ID onward)
//   mem_ready      completion handshake for the current memory access
//   bcond          ALU branch condition, consumed by datapath PC gating
//   halt_cond      x17==10, sampled in ID for ECALL
//   pc_write ..    datapath write enables and single-bit selects
//   alu_src_a      00 PC, 01 OldPC, 10 rs1
//   alu_src_b      00 rs2, 01 constant 4, 10 immediate
//   alu_op         00 add, 01 subtract, 10 decode from funct fields
//   wb_sel         00 ALUOut, 01 MDR, 10 OldPC+4
//   halted         processor stopped
//   state          IF=0, ID=1, EX=2, MEM=3, WB=4, HALTED=5
// ---------------------------------------------------------------------------
module multi_cycle_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       bcond,
    input  logic       halt_cond,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       pc_source,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IF     = 3'd0,
        ST_ID     = 3'd1,
        ST_EX     = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    state_t current_state;
    state_t next_state;

    // The branch outcome only gates the PC write inside the datapath
    // (pc_write_cond & bcond), so the FSM itself never looks at it.
    logic unused_bcond;
    assign unused_bcond = bcond;

    assign state = current_state;

    // State register. Reset is asynchronous so that an access in flight
    // (e.g. a pending store) is abandoned immediately rather than at the
    // next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_state <= ST_IF;
        end else begin
            current_state <= next_state;
        end
    end

    // Next-state and Moore/Mealy outputs. Everything defaults to zero so
    // each state only names the controls it actually asserts. The only
    // input-dependent outputs are the IF write enables and the memory
    // wait loops, both driven by mem_ready.
    always_comb begin
        next_state    = current_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        pc_source     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        wb_sel        = 2'b00;
        halted        = 1'b0;

        case (current_state)
            ST_IF: begin
                // PC+4 is computed while the fetch is outstanding; IR and
                // PC are committed only on the cycle memory completes.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    next_state = ST_ID;
                end
            end

            ST_ID: begin
                // Speculative branch/jump target: ALUOut <= OldPC + imm.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ECALL:  next_state = halt_cond ? ST_HALTED : ST_IF;
                    OP_R, OP_IARITH, OP_LOAD, OP_STORE,
                    OP_BRANCH, OP_JAL, OP_JALR:
                               next_state = ST_EX;
                    default:   next_state = ST_IF;
                endcase
            end

            ST_EX: begin
                next_state = ST_IF;
                case (opcode)
                    OP_R: begin
                        alu_src_a  = 2'b10;
                        alu_op     = 2'b10;
                        next_state = ST_WB;
                    end
                    OP_IARITH: begin
                        alu_src_a  = 2'b10;
                        alu_src_b  = 2'b10;
                        alu_op     = 2'b10;
                        next_state = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a  = 2'b10;
                        alu_src_b  = 2'b10;
                        next_state = ST_MEM;
                    end
                    OP_BRANCH: begin
                        // Compare rs1-rs2; target already sits in ALUOut.
                        alu_src_a     = 2'b10;
                        alu_op        = 2'b01;
                        pc_write_cond = 1'b1;
                        pc_source     = 1'b1;
                        next_state    = ST_IF;
                    end
                    OP_JAL: begin
                        pc_write   = 1'b1;
                        pc_source  = 1'b1;
                        next_state = ST_WB;
                    end
                    OP_JALR: begin
                        // rs1+imm goes straight from the ALU result to PC.
                        alu_src_a  = 2'b10;
                        alu_src_b  = 2'b10;
                        pc_write   = 1'b1;
                        next_state = ST_WB;
                    end
                    default: next_state = ST_IF;
                endcase
            end

            ST_MEM: begin
                next_state = ST_IF;
                case (opcode)
                    OP_LOAD: begin
                        mem_read   = 1'b1;
                        i_or_d     = 1'b1;
                        next_state = mem_ready ? ST_WB : ST_MEM;
                    end
                    OP_STORE: begin
                        mem_write  = 1'b1;
                        i_or_d     = 1'b1;
                        next_state = mem_ready ? ST_IF : ST_MEM;
                    end
                    default: next_state = ST_IF;
                endcase
            end

            ST_WB: begin
                reg_write = 1'b1;
                case (opcode)
                    OP_LOAD:         wb_sel = 2'b01;
                    OP_JAL, OP_JALR: wb_sel = 2'b10;
                    default:         wb_sel = 2'b00;
                endcase
                next_state = ST_IF;
            end

            ST_HALTED: begin
                halted     = 1'b1;
                next_state = ST_HALTED;
            end

            // Encodings 6 and 7 are unreachable in normal operation; recover
            // to a fetch with all controls idle.
            default: next_state = ST_IF;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_control_unit
//
// Directed bench for multi_cycle_control_unit. A route-based model (each
// instruction class maps to a list of phases after ID) predicts state and
// all outputs; a compare process checks them every falling edge. Directed
// sequences add literal expectations for the key cycles.
// ---------------------------------------------------------------------------
module tb_multi_cycle_control_unit;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       bcond = 1'b0;
    logic       halt_cond = 1'b0;
    logic       pc_write, pc_write_cond, ir_write, reg_write;
    logic       mem_read, mem_write, i_or_d, pc_source;
    logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
    logic       halted;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    multi_cycle_control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .bcond(bcond), .halt_cond(halt_cond),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .wb_sel(wb_sel),
        .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    // Phases an instruction visits after ID, in order; 0 (IF) past the end.
    function automatic int route(logic [6:0] op, logic hc, int k);
        int r[$];
        case (op)
            OP_R, OP_IARITH, OP_JAL, OP_JALR: r = '{2, 4};
            OP_LOAD:   r = '{2, 3, 4};
            OP_STORE:  r = '{2, 3};
            OP_BRANCH: r = '{2};
            OP_ECALL:  if (hc) r = '{5};
            default:   r = '{};
        endcase
        return (k < r.size()) ? r[k] : 0;
    endfunction

    // Control word each phase must present, written from the control table.
    function automatic logic [16:0] expect_out(int st, logic [6:0] op, logic mr);
        logic pw, pwc, irw, rw, mrd, mwr, iod, psrc, hlt;
        logic [1:0] sa, sb, aop, wb;
        {pw, pwc, irw, rw, mrd, mwr, iod, psrc, hlt} = '0;
        {sa, sb, aop, wb} = '0;
        if (st == 0) begin
            mrd = 1; sb = 2'd1; irw = mr; pw = mr;
        end else if (st == 1) begin
            sa = 2'd1; sb = 2'd2;
        end else if (st == 2) begin
            if (op == OP_R)           begin sa = 2'd2; aop = 2'd2; end
            else if (op == OP_IARITH) begin sa = 2'd2; sb = 2'd2; aop = 2'd2; end
            else if (op == OP_LOAD || op == OP_STORE) begin sa = 2'd2; sb = 2'd2; end
            else if (op == OP_BRANCH) begin sa = 2'd2; aop = 2'd1; pwc = 1; psrc = 1; end
            else if (op == OP_JAL)    begin pw = 1; psrc = 1; end
            else if (op == OP_JALR)   begin sa = 2'd2; sb = 2'd2; pw = 1; end
        end else if (st == 3) begin
            if (op == OP_LOAD)  begin mrd = 1; iod = 1; end
            if (op == OP_STORE) begin mwr = 1; iod = 1; end
        end else if (st == 4) begin
            rw = 1;
            wb = (op == OP_LOAD) ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0;
        end else if (st == 5) begin
            hlt = 1;
        end
        return {pw, pwc, irw, rw, mrd, mwr, iod, psrc, sa, sb, aop, wb, hlt};
    endfunction

    int   m_state = 0;
    int   m_step  = 0;
    logic m_hc    = 1'b0;

    // Model progression: IF waits for memory, ID picks the route, MEM waits
    // for memory, HALTED holds, every other phase walks the route.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 0;
            m_step  <= 0;
        end else if (m_state == 0) begin
            if (mem_ready) m_state <= 1;
        end else if (m_state == 1) begin
            m_hc    <= halt_cond;
            m_state <= route(opcode, halt_cond, 0);
            m_step  <= 1;
        end else if (m_state == 5) begin
            m_state <= 5;
        end else if (m_state == 3 && !mem_ready) begin
            m_state <= 3;
        end else begin
            m_state <= route(opcode, m_hc, m_step);
            m_step  <= m_step + 1;
        end
    end

    logic [19:0] actual_word;
    assign actual_word = {state, pc_write, pc_write_cond, ir_write, reg_write,
                          mem_read, mem_write, i_or_d, pc_source,
                          alu_src_a, alu_src_b, alu_op, wb_sel, halted};

    // Full-word comparison against the model once per cycle.
    always @(negedge clk) begin
        logic [19:0] req;
        req = {m_state[2:0], expect_out(m_state, opcode, mem_ready)};
        total++;
        if (actual_word !== req) begin
            bad++;
            $display("[TB] FAIL cycle_word t=%0t actual=%h required=%h", $time, actual_word, req);
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Drive one cycle's inputs and move to the falling edge, checking state.
    task automatic applyStimulus(input logic [6:0] op, input logic mr, input logic bc,
                                 input logic hc, input int exp_state, input string name);
        opcode = op; mem_ready = mr; bcond = bc; halt_cond = hc;
        @(negedge clk);
        checkOutput(name, 8'(state), 8'(exp_state));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values, with and without mem_ready
        @(negedge clk);
        checkOutput("rst_state", 8'(state), 8'd0);
        checkOutput("rst_halted", 8'(halted), 8'd0);
        checkOutput("rst_mem_read", 8'(mem_read), 8'd1);
        checkOutput("rst_i_or_d", 8'(i_or_d), 8'd0);
        checkOutput("rst_alu_src_b", 8'(alu_src_b), 8'd1);
        checkOutput("rst_ir_write_lo", 8'(ir_write), 8'd0);
        mem_ready = 1'b1;
        #1;
        checkOutput("rst_ir_write_hi", 8'(ir_write), 8'd1);
        checkOutput("rst_pc_write_hi", 8'(pc_write), 8'd1);
        tick();
        reset = 1'b0;

        // ADD, zero-wait: 0,1,2,4,0
        applyStimulus(OP_R, 1, 0, 0, 0, "add_if");
        checkOutput("add_if_rw", 8'(reg_write), 8'd0);
        tick();
        applyStimulus(OP_R, 1, 0, 0, 1, "add_id");
        tick();
        applyStimulus(OP_R, 1, 0, 0, 2, "add_ex");
        checkOutput("add_ex_aluop", 8'(alu_op), 8'd2);
        checkOutput("add_ex_rw", 8'(reg_write), 8'd0);
        tick();
        applyStimulus(OP_R, 1, 0, 0, 4, "add_wb");
        checkOutput("add_wb_rw", 8'(reg_write), 8'd1);
        checkOutput("add_wb_sel", 8'(wb_sel), 8'd0);
        tick();

        // LOAD with two wait cycles in MEM
        applyStimulus(OP_LOAD, 1, 0, 0, 0, "ld_if"); tick();
        applyStimulus(OP_LOAD, 1, 0, 0, 1, "ld_id"); tick();
        applyStimulus(OP_LOAD, 1, 0, 0, 2, "ld_ex"); tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OP_LOAD, (i == 2), 0, 0, 3, "ld_mem");
            checkOutput("ld_mem_rd", 8'(mem_read), 8'd1);
            checkOutput("ld_mem_iod", 8'(i_or_d), 8'd1);
            tick();
        end
        applyStimulus(OP_LOAD, 1, 0, 0, 4, "ld_wb");
        checkOutput("ld_wb_sel", 8'(wb_sel), 8'd1);
        tick();

        // BRANCH not taken then taken: both 3 cycles
        for (int b = 0; b < 2; b++) begin
            applyStimulus(OP_BRANCH, 1, 1'(b), 0, 0, "br_if"); tick();
            applyStimulus(OP_BRANCH, 1, 1'(b), 0, 1, "br_id"); tick();
            applyStimulus(OP_BRANCH, 1, 1'(b), 0, 2, "br_ex");
            checkOutput("br_ex_pwc", 8'(pc_write_cond), 8'd1);
            checkOutput("br_ex_psrc", 8'(pc_source), 8'd1);
            checkOutput("br_ex_aluop", 8'(alu_op), 8'd1);
            checkOutput("br_ex_pw", 8'(pc_write), 8'd0);
            tick();
        end

        // Fetch stall, I-arith, JALR, unknown opcode, ECALL without halt,
        // and a zero-wait STORE; the cycle compare covers their outputs.
        applyStimulus(OP_IARITH, 0, 0, 0, 0, "ia_stall"); tick();
        applyStimulus(OP_IARITH, 1, 0, 0, 0, "ia_if"); tick();
        applyStimulus(OP_IARITH, 1, 0, 0, 1, "ia_id"); tick();
        applyStimulus(OP_IARITH, 1, 0, 0, 2, "ia_ex"); tick();
        applyStimulus(OP_IARITH, 1, 0, 0, 4, "ia_wb"); tick();
        applyStimulus(OP_JALR, 1, 0, 0, 0, "jalr_if"); tick();
        applyStimulus(OP_JALR, 1, 0, 0, 1, "jalr_id"); tick();
        applyStimulus(OP_JALR, 1, 0, 0, 2, "jalr_ex"); tick();
        applyStimulus(OP_JALR, 1, 0, 0, 4, "jalr_wb");
        checkOutput("jalr_wb_sel", 8'(wb_sel), 8'd2);
        tick();
        applyStimulus(OP_BAD, 1, 0, 0, 0, "bad_if"); tick();
        applyStimulus(OP_BAD, 1, 0, 0, 1, "bad_id"); tick();
        applyStimulus(OP_ECALL, 1, 0, 0, 0, "ec0_if"); tick();
        applyStimulus(OP_ECALL, 1, 0, 0, 1, "ec0_id"); tick();
        applyStimulus(OP_STORE, 1, 0, 0, 0, "st_if"); tick();
        applyStimulus(OP_STORE, 1, 0, 0, 1, "st_id"); tick();
        applyStimulus(OP_STORE, 1, 0, 0, 2, "st_ex"); tick();
        applyStimulus(OP_STORE, 1, 0, 0, 3, "st_mem");
        checkOutput("st_mem_wr", 8'(mem_write), 8'd1);
        checkOutput("st_mem_rd", 8'(mem_read), 8'd0);
        tick();

        // ECALL with halt: HALTED absorbs random inputs, reset recovers
        applyStimulus(OP_ECALL, 1, 0, 1, 0, "hlt_if"); tick();
        applyStimulus(OP_ECALL, 1, 0, 1, 1, "hlt_id"); tick();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5, "hlt_state");
            checkOutput("hlt_halted", 8'(halted), 8'd1);
            tick();
        end
        reset = 1'b1;
        applyStimulus(OP_STORE, 0, 0, 0, 0, "hlt_rst_state");
        checkOutput("hlt_rst_halted", 8'(halted), 8'd0);
        tick();
        reset = 1'b0;

        // STORE interrupted by a reset pulse while waiting in MEM
        applyStimulus(OP_STORE, 1, 0, 0, 0, "st2_if"); tick();
        applyStimulus(OP_STORE, 1, 0, 0, 1, "st2_id"); tick();
        applyStimulus(OP_STORE, 1, 0, 0, 2, "st2_ex"); tick();
        applyStimulus(OP_STORE, 0, 0, 0, 3, "st2_mem");
        checkOutput("st2_mem_wr", 8'(mem_write), 8'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("st2_async_state", 8'(state), 8'd0);
        checkOutput("st2_async_wr", 8'(mem_write), 8'd0);
        checkOutput("st2_async_rd", 8'(mem_read), 8'd1);
        #1 reset = 1'b0;
        tick();

        // JAL after the interrupted store
        applyStimulus(OP_JAL, 1, 0, 0, 0, "jal_if"); tick();
        applyStimulus(OP_JAL, 1, 0, 0, 1, "jal_id"); tick();
        applyStimulus(OP_JAL, 1, 0, 0, 2, "jal_ex");
        checkOutput("jal_ex_pw", 8'(pc_write), 8'd1);
        checkOutput("jal_ex_psrc", 8'(pc_source), 8'd1);
        tick();
        applyStimulus(OP_JAL, 1, 0, 0, 4, "jal_wb");
        checkOutput("jal_wb_sel", 8'(wb_sel), 8'd2);
        checkOutput("jal_wb_rw", 8'(reg_write), 8'd1);
        tick();
        applyStimulus(OP_JAL, 1, 0, 0, 0, "jal_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
